line_editor: RTL

- Sits directly downstream of key_in: consumes its one-cycle ascii/cursor/backspace strobes and maintains an editable line buffer with a cursor.
- On "down" (enter), streams the committed line out with a valid/ready handshake toward a display or host stage.
- Also exports length, cursor position and the character under the cursor for hex/LED debug display.

---
 rtl/line_editor_pkg.sv | 19 +
 rtl/line_buf_regs.sv | 33 +++
 rtl/line_editor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/line_editor_pkg.sv
// Shared types and constants for the line editor: FSM states, the null
// character and the length/cursor width derivation.
package line_editor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INS_SHIFT,
        ST_DEL_SHIFT,
        ST_EMIT
    } state_t;

    localparam logic [7:0] NULL_CHAR = 8'h00;

    // Length and cursor must be able to hold DEPTH itself, not just DEPTH-1.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/line_buf_regs.sv
// DEPTH x 8 character store. It has one write port that takes either external
// data or a copy of another entry, plus combinational reads for cursor and emit.
module line_buf_regs
    import line_editor_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             copy_en,
    input  logic [IDX_W-1:0] copy_src,
    input  logic [IDX_W-1:0] char_idx,
    output logic [7:0]       char_data,
    input  logic [IDX_W-1:0] emit_idx,
    output logic [7:0]       emit_data
);

    logic [7:0] mem [DEPTH];

    // Contents survive reset; only the length bounds what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= copy_en ? mem[copy_src] : wr_data;
        end
    end

    assign char_data = mem[char_idx];
    assign emit_data = mem[emit_idx];

endmodule

// File: rtl/line_editor.sv
// Editable line buffer with cursor. Mid-line inserts and deletes shift one
// entry per cycle, and a commit streams the line out over valid/ready.
module line_editor
    import line_editor_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = len_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_sclr_n,
    input  logic [7:0]       i_ascii,
    input  logic             i_ascii_en,
    input  logic             i_left_en,
    input  logic             i_right_en,
    input  logic             i_backspace_en,
    input  logic             i_down_en,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data,
    output logic             o_out_valid,
    output logic             o_out_last,
    output logic [LEN_W-1:0] o_len,
    output logic [LEN_W-1:0] o_cursor,
    output logic [7:0]       o_char,
    output logic             o_full,
    output logic             o_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state, state_next;
    logic [LEN_W-1:0] len, len_next;
    logic [LEN_W-1:0] cursor, cursor_next;
    logic [LEN_W-1:0] ptr, ptr_next;
    logic [LEN_W-1:0] idx, idx_next;
    logic [7:0]       ch, ch_next;
    logic             wr_en, copy_en, last;
    logic [IDX_W-1:0] wr_idx, copy_src;
    logic [7:0]       wr_data, char_data, emit_data;

    line_buf_regs #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_buf (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .copy_en   (copy_en),
        .copy_src  (copy_src),
        .char_idx  (IDX_W'(cursor)),
        .char_data (char_data),
        .emit_idx  (IDX_W'(idx)),
        .emit_data (emit_data)
    );

    always_comb begin
        state_next  = state;
        len_next    = len;
        cursor_next = cursor;
        ptr_next    = ptr;
        idx_next    = idx;
        ch_next     = ch;
        wr_en       = 1'b0;
        copy_en     = 1'b0;
        wr_idx      = '0;
        copy_src    = '0;
        wr_data     = ch;
        last        = ((idx + LEN_W'(1)) == len);

        case (state)
            ST_IDLE: begin
                // Only the highest-priority strobe is considered; a no-op still drops the rest.
                if (i_backspace_en) begin
                    if (cursor != '0) begin
                        if (cursor == len) begin
                            cursor_next = cursor - LEN_W'(1);
                            len_next    = len - LEN_W'(1);
                        end else begin
                            ptr_next   = cursor;
                            state_next = ST_DEL_SHIFT;
                        end
                    end
                end else if (i_ascii_en) begin
                    if (len != LEN_W'(DEPTH)) begin
                        if (cursor == len) begin
                            wr_en       = 1'b1;
                            wr_idx      = IDX_W'(len);
                            wr_data     = i_ascii;
                            cursor_next = cursor + LEN_W'(1);
                            len_next    = len + LEN_W'(1);
                        end else begin
                            ch_next    = i_ascii;
                            ptr_next   = len;
                            state_next = ST_INS_SHIFT;
                        end
                    end
                end else if (i_left_en) begin
                    if (cursor != '0) cursor_next = cursor - LEN_W'(1);
                end else if (i_right_en) begin
                    if (cursor != len) cursor_next = cursor + LEN_W'(1);
                end else if (i_down_en) begin
                    if (len != '0) begin
                        idx_next   = '0;
                        state_next = ST_EMIT;
                    end
                end
            end
            ST_INS_SHIFT: begin
                if (ptr > cursor) begin
                    wr_en    = 1'b1;
                    copy_en  = 1'b1;
                    wr_idx   = IDX_W'(ptr);
                    copy_src = IDX_W'(ptr - LEN_W'(1));
                    ptr_next = ptr - LEN_W'(1);
                end else begin
                    wr_en       = 1'b1;
                    wr_idx      = IDX_W'(cursor);
                    wr_data     = ch;
                    cursor_next = cursor + LEN_W'(1);
                    len_next    = len + LEN_W'(1);
                    state_next  = ST_IDLE;
                end
            end
            ST_DEL_SHIFT: begin
                if (ptr < len) begin
                    wr_en    = 1'b1;
                    copy_en  = 1'b1;
                    wr_idx   = IDX_W'(ptr - LEN_W'(1));
                    copy_src = IDX_W'(ptr);
                    ptr_next = ptr + LEN_W'(1);
                end else begin
                    cursor_next = cursor - LEN_W'(1);
                    len_next    = len - LEN_W'(1);
                    state_next  = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (i_out_ready) begin
                    if (last) begin
                        len_next    = '0;
                        cursor_next = '0;
                        state_next  = ST_IDLE;
                    end else begin
                        idx_next = idx + LEN_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state  <= ST_IDLE;
            len    <= '0;
            cursor <= '0;
            ptr    <= '0;
            idx    <= '0;
            ch     <= NULL_CHAR;
        end else begin
            state  <= state_next;
            len    <= len_next;
            cursor <= cursor_next;
            ptr    <= ptr_next;
            idx    <= idx_next;
            ch     <= ch_next;
        end
    end

    assign o_len       = len;
    assign o_cursor    = cursor;
    assign o_char      = (cursor < len) ? char_data : NULL_CHAR;
    assign o_full      = (len == LEN_W'(DEPTH));
    assign o_busy      = (state != ST_IDLE);
    assign o_out_valid = (state == ST_EMIT);
    assign o_out_last  = o_out_valid && last;
    assign o_out_data  = o_out_valid ? emit_data : NULL_CHAR;

endmodule
